// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with zero-cycle lookup, saturating
// direction counters, round-robin replacement and a multi-cycle flush sweep.
module btb_assoc #(
    parameter int INDEX_LEN = 6,
    parameter int WAYS      = 2,
    parameter int CNT_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush,
    output logic        busy
);

    localparam int SETS  = 1 << INDEX_LEN;
    localparam int TAG_W = 32 - INDEX_LEN - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state_q, state_d;
    logic [INDEX_LEN-1:0] sweep_q, sweep_d;

    logic [WAYS-1:0]     valid_q  [SETS];
    logic [WAY_W-1:0]    vptr_q   [SETS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [31:0]         target_q [SETS][WAYS];
    logic [CNT_BITS-1:0] cnt_q    [SETS][WAYS];

    logic [INDEX_LEN-1:0] lk_idx, u_idx;
    logic [TAG_W-1:0]     lk_tag, u_tag;
    logic                 u_hit, u_free, do_upd, do_alloc;
    logic [WAY_W-1:0]     u_way, free_way, victim;
    logic [CNT_BITS-1:0]  cnt_weak;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{pc_if[1:0], upd_pc[1:0]};

    assign lk_idx = pc_if[INDEX_LEN+1:2];
    assign lk_tag = pc_if[31:INDEX_LEN+2];
    assign u_idx  = upd_pc[INDEX_LEN+1:2];
    assign u_tag  = upd_pc[31:INDEX_LEN+2];

    assign busy     = (state_q == SWEEP);
    assign do_upd   = upd_valid && (state_q == IDLE);
    assign do_alloc = do_upd && !u_hit && upd_taken;

    always_comb begin
        cnt_weak = '0;
        cnt_weak[CNT_BITS-1] = 1'b1;
    end

    // Lookup: first matching way wins, everything forced low during a sweep.
    always_comb begin
        hit        = 1'b0;
        pred_taken = 1'b0;
        pred_pc    = '0;
        if (state_q == IDLE) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (!hit && valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                    hit        = 1'b1;
                    pred_taken = cnt_q[lk_idx][w][CNT_BITS-1];
                    pred_pc    = target_q[lk_idx][w];
                end
            end
        end
    end

    always_comb begin
        u_hit    = 1'b0;
        u_way    = '0;
        u_free   = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!u_hit && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!u_free && !valid_q[u_idx][w]) begin
                u_free   = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        victim = u_free ? free_way : vptr_q[u_idx];
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = SWEEP;
                    sweep_d = '0;
                end
            end
            SWEEP: begin
                sweep_d = sweep_q + INDEX_LEN'(1);
                if (sweep_q == INDEX_LEN'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else if (state_q == SWEEP) begin
            valid_q[sweep_q] <= '0;
        end else if (do_alloc) begin
            valid_q[u_idx][victim] <= 1'b1;
            // Pointer only advances when a valid entry was displaced.
            if (!u_free) begin
                vptr_q[u_idx] <= (WAYS > 1) ? vptr_q[u_idx] + WAY_W'(1) : '0;
            end
        end
    end

    // Payload arrays carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (do_upd && u_hit) begin
            if (upd_taken) begin
                target_q[u_idx][u_way] <= upd_target;
                if (cnt_q[u_idx][u_way] != '1) begin
                    cnt_q[u_idx][u_way] <= cnt_q[u_idx][u_way] + CNT_BITS'(1);
                end
            end else if (cnt_q[u_idx][u_way] != '0) begin
                cnt_q[u_idx][u_way] <= cnt_q[u_idx][u_way] - CNT_BITS'(1);
            end
        end else if (do_alloc) begin
            tag_q[u_idx][victim]    <= u_tag;
            target_q[u_idx][victim] <= upd_target;
            cnt_q[u_idx][victim]    <= cnt_weak;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed and random checks of btb_assoc against a behavioural BTB model.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        hit, pred_taken, busy;
    logic [31:0] pred_pc;
    logic        upd_valid, upd_taken, flush;
    logic [31:0] upd_pc, upd_target;

    always #5 clk = ~clk;

    btb_assoc #(.INDEX_LEN(6), .WAYS(2), .CNT_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .hit(hit),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: 64 sets x 2 ways, counters as plain integers 0..3.
    bit          mv   [64][2];
    logic [23:0] mtag [64][2];
    logic [31:0] mtgt [64][2];
    int          mcnt [64][2];
    int          mptr [64];
    int          m_left;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            mptr[s]  = 0;
        end
        m_left = 0;
    endfunction

    function automatic void model_update(logic [31:0] pc, bit tk, logic [31:0] tg);
        int s;
        int w;
        int v;
        logic [23:0] t;
        s = int'((pc >> 2) % 64);
        t = pc[31:8];
        w = -1;
        v = -1;
        for (int i = 0; i < 2; i++)
            if (w < 0 && mv[s][i] && mtag[s][i] == t) w = i;
        if (w >= 0) begin
            if (tk) begin
                mcnt[s][w] = (mcnt[s][w] < 3) ? mcnt[s][w] + 1 : 3;
                mtgt[s][w] = tg;
            end else begin
                mcnt[s][w] = (mcnt[s][w] > 0) ? mcnt[s][w] - 1 : 0;
            end
        end else if (tk) begin
            for (int i = 0; i < 2; i++)
                if (v < 0 && !mv[s][i]) v = i;
            if (v < 0) begin
                v = mptr[s];
                mptr[s] = (mptr[s] + 1) % 2;
            end
            mv[s][v]   = 1'b1;
            mtag[s][v] = t;
            mtgt[s][v] = tg;
            mcnt[s][v] = 2;
        end
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_left > 0) begin
            mv[64 - m_left][0] = 1'b0;
            mv[64 - m_left][1] = 1'b0;
            m_left--;
        end else begin
            if (upd_valid) model_update(upd_pc, upd_taken, upd_target);
            if (flush) m_left = 64;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic look(string tag, logic [31:0] pc);
        logic        eh = 1'b0;
        logic        ep = 1'b0;
        logic [31:0] epc = '0;
        int          s;
        logic [23:0] t;
        pc_if = pc;
        #1;
        s = int'((pc >> 2) % 64);
        t = pc[31:8];
        if (m_left == 0) begin
            for (int i = 0; i < 2; i++) begin
                if (!eh && mv[s][i] && mtag[s][i] == t) begin
                    eh  = 1'b1;
                    ep  = (mcnt[s][i] >= 2);
                    epc = mtgt[s][i];
                end
            end
        end
        chk({tag, "_hit"}, hit, eh);
        chk({tag, "_taken"}, pred_taken, ep);
        chk({tag, "_pc"}, pred_pc, epc);
        chk({tag, "_busy"}, busy, m_left > 0);
    endtask

    task automatic upd(bit v, logic [31:0] pc, bit tk, logic [31:0] tg);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
    endtask

    initial begin
        bit seq [8];
        int busy_cycles;
        rst_n = 1'b0;
        pc_if = '0;
        flush = 1'b0;
        upd(0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        look("after_reset", 32'h100);

        // First allocation; same-cycle lookup must still see the old contents.
        upd(1, 32'h100, 1, 32'h200);
        look("same_cycle", 32'h100);
        tick();
        upd(0, 0, 0, 0);
        look("alloc", 32'h100);
        look("alloc_lowbits", 32'h102);

        // Counter saturation in both directions.
        seq = '{0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            upd(1, 32'h100, seq[i], 32'h200);
            tick();
            upd(0, 0, 0, 0);
            look($sformatf("cnt%0d", i), 32'h100);
        end

        // Round-robin replacement in set 0.
        upd(1, 32'h200, 1, 32'h1200); tick();
        upd(1, 32'h300, 1, 32'h1300); tick();
        upd(0, 0, 0, 0);
        look("evict1_100", 32'h100);
        look("evict1_200", 32'h200);
        look("evict1_300", 32'h300);
        upd(1, 32'h400, 1, 32'h1400); tick();
        upd(0, 0, 0, 0);
        look("evict2_200", 32'h200);
        look("evict2_400", 32'h400);
        look("evict2_300", 32'h300);

        upd(1, 32'h500, 0, 32'h1500); tick();
        upd(0, 0, 0, 0);
        look("nt_miss", 32'h500);

        // Flush sweep with an update issued mid-sweep.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            look("sweep", 32'h300);
            if (i == 10) upd(1, 32'h600, 1, 32'h1600);
            tick();
            upd(0, 0, 0, 0);
            busy_cycles++;
        end
        chk("busy_len", busy_cycles, 64);
        look("post_flush_300", 32'h300);
        look("post_flush_400", 32'h400);
        look("post_flush_600", 32'h600);

        // Random traffic over a few sets and tags.
        for (int i = 0; i < 400; i++) begin
            upd(1'($urandom_range(0, 1)),
                32'(($urandom_range(1, 4) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0), $urandom);
            flush = ($urandom_range(0, 99) == 0);
            look("rnd", 32'(($urandom_range(1, 4) << 8) | ($urandom_range(0, 1) << 2)));
            tick();
        end
        upd(0, 0, 0, 0);
        flush = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("rnd_drain", busy, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        upd(1, 32'h700, 1, 32'h1700); tick();
        upd(0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        look("pre_rst", 32'h700);
        rst_n = 1'b0;
        model_reset();
        look("rst_mid", 32'h700);
        tick();
        rst_n = 1'b1;
        tick();
        look("post_rst", 32'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter INDEX_LEN, default 6, meaning log2 of set count; SETS = 2^INDEX_LEN.
REQ-002 SHALL have parameter WAYS, default 2, meaning ways per set; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter CNT_BITS, default 2, meaning width of the per-entry saturating direction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port pc_if  input  32  IF-stage lookup PC.
REQ-007 SHALL have port hit  output  1  pc_if matches a valid entry.
REQ-008 SHALL have port pred_taken  output  1  MSB of the hit entry's counter.
REQ-009 SHALL have port pred_pc  output  32  stored target of the hit entry.
REQ-010 SHALL have port upd_valid  input  1  ID-stage branch resolution valid this cycle.
REQ-011 SHALL have port upd_pc  input  32  PC of resolved branch.
REQ-012 SHALL have port upd_taken  input  1  actual branch direction.
REQ-013 SHALL have port upd_target  input  32  actual branch target.
REQ-014 SHALL have port flush  input  1  one-cycle request to invalidate all entries.
REQ-015 SHALL have port busy  output  1  flush sweep in progress.

Function
REQ-016 SHALL index with PC[INDEX_LEN+1:2] and tag with PC[31:INDEX_LEN+2]; PC[1:0] ignored.
REQ-017 SHALL store per entry: valid, tag, 32-bit target, CNT_BITS counter; per set: round-robin victim pointer, log2(WAYS) bits (none when WAYS=1).
REQ-018 SHALL produce hit/pred_taken/pred_pc combinationally from pc_if and current state (zero-cycle lookup).
REQ-019 SHALL drive pred_taken=0 and pred_pc=0 on miss; on multiple matches (illegal) SHALL select lowest way.
REQ-020 SHALL, on upd_valid with tag hit in set: taken -> counter +1 saturating at all-ones, target <= upd_target; not taken -> counter -1 saturating at 0, target unchanged.
REQ-021 SHALL, on upd_valid, tag miss, upd_taken=1: allocate entry with valid=1, tag, target=upd_target, counter=weakly taken (MSB 1, rest 0).
REQ-022 SHALL, on upd_valid, tag miss, upd_taken=0: not allocate; no state change.
REQ-023 SHALL choose victim as lowest-numbered invalid way; if all valid, way at set's pointer, then pointer increments modulo WAYS; pointer unchanged when an invalid way is used.
REQ-024 SHALL make updates visible to lookup the cycle after the update edge; same-cycle lookup sees old contents.
REQ-025 SHALL implement FSM IDLE/SWEEP: IDLE + flush -> SWEEP with sweep counter 0; SWEEP clears valid of all ways in set[counter] each cycle, counter +1; at counter SETS-1 -> IDLE.
REQ-026 SHALL assert busy exactly in SWEEP (SETS cycles per flush).
REQ-027 SHALL, while busy, force hit=0, pred_taken=0, pred_pc=0, ignore upd_valid, ignore flush.
REQ-028 SHALL not clear victim pointers, tags, targets or counters on sweep.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all valid bits, victim pointers, sweep counter, state to IDLE; hit=0, pred_taken=0, pred_pc=0, busy=0.
REQ-030 SHALL, on reset during SWEEP, abort sweep and return to IDLE; tags/targets/counters need not reset.

Verification (INDEX_LEN=6, WAYS=2, CNT_BITS=2)
REQ-031 SHALL cover: release reset, pc_if=0x100 -> hit=0, pred_taken=0, pred_pc=0, busy=0.
REQ-032 SHALL cover: update 0x100 taken target 0x200; next cycle pc_if=0x100 -> hit=1, pred_taken=1, pred_pc=0x200; pc_if=0x102 also hits.
REQ-033 SHALL cover: two not-taken updates on 0x100 -> hit=1, pred_taken=0; third -> counter stays 0; three taken -> counter 3, fourth stays 3.
REQ-034 SHALL cover: taken updates 0x100, 0x200, 0x300 (all set 0) -> 0x300 evicts 0x100; 0x100 miss, 0x200 and 0x300 hit; fourth 0x400 evicts 0x200.
REQ-035 SHALL cover: not-taken update 0x500 on miss -> next-cycle lookup 0x500 hit=0.
REQ-036 SHALL cover: flush pulse with entries valid -> busy high for exactly 64 cycles, hit=0 throughout, update during busy dropped, all prior entries miss afterwards; rst_n low mid-sweep -> busy=0 immediately.
